dram_port_arbiter: RTL and testbench
====================================

// Module: dram_port_arbiter
// PURPOSE
//  Two-requester arbiter in front of the data-RAM wrapper (mem_wr/mem_rd/mem_op/addr/wdata -> rdata, 1-cycle read latency).
//  Port 0 = core LSU, port 1 = DMA/debug loader. Grants at most one access per cycle and steers the read return to the issuer.
//  Supports a port-0 lock for back-to-back exclusive sequences and a starvation guard for port 1.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width
//  MAX_WAIT  8   cycles port 1 may wait before it is forced ahead of port 0 (fixed-priority mode); 1..255
// PORTS
//  sclk          in   1   clock
//  rst           in   1   synchronous active-high reset
//  m0_valid      in   1   port-0 request
//  m0_wr         in   1   1=store, 0=load
//  m0_op         in   3   funct3 load/store type (SB/SH/SW/LB/LH/LW/LBU/LHU)
//  m0_addr       in   AW  byte address
//  m0_wdata      in   DW  store data
//  m0_lock       in   1   hold ownership after this grant
//  m0_ready      out  1   request accepted this cycle
//  m0_rvalid     out  1   load data valid (one cycle after accepted load)
//  m0_rdata      out  DW  load data
//  m1_*          -    -   same set as m0_* except no m1_lock
//  mem_wr        out  1   to DRAM wrapper
//  mem_rd        out  1   to DRAM wrapper
//  mem_op        out  3   to DRAM wrapper
//  mem_addr      out  AW  to DRAM wrapper
//  mem_wdata     out  DW  to DRAM wrapper
//  mem_rdata     in   DW  from DRAM wrapper, valid cycle after mem_rd
// BEHAVIOUR
//  - Accept = mX_valid && mX_ready. Ready is combinational from valid, state and counters; never depends on rdata.
//  - Granted port drives mem_* in the same cycle. mem_wr=mX_wr, mem_rd=!mX_wr. No grant -> mem_wr=mem_rd=0, op/addr/wdata=0.
//  - Read return: registered rsel and rpend (1 = last cycle's accept was a load). Next cycle, m{rsel}_rvalid=1 and m{rsel}_rdata=mem_rdata.
//    Other port's rdata=0. Pipelined loads can be accepted every cycle.
//  - FSM states:
//    - IDLE: normal arbitration.
//    - LOCK0: port 0 owns the RAM; m1_ready=0.
//    - Transitions:
//      - IDLE->LOCK0 on port-0 accept with m0_lock=1.
//      - LOCK0->IDLE on port-0 accept with m0_lock=0.
//      - Cycles with m0_valid=0 stay in LOCK0.
//  - Fixed priority (macro absent), IDLE state:
//    - Port 0 wins a tie.
//    - wait_cnt (8b) increments each cycle m1_valid && !m1_ready and saturates. It clears on port-1 accept or when m1_valid=0.
//    - wait_cnt>=MAX_WAIT forces port 1 ahead of port 0 for one grant. Not applied in LOCK0.
//  - Simultaneous lock request and forced port-1 grant: port 1 wins. m0_lock is ignored because port 0 was not accepted.
//  - Reset: state=IDLE, wait_cnt=0, rpend=0, rsel=0, last=1.
//    All outputs 0 except readies (combinational), which follow the rules above once rst drops.
//  - Reset mid-operation: pending read return dropped (rvalid=0 next cycle); lock released.
// CONFIGURATION
//  DRAM_ARB_RR_EN defined:
//    - IDLE uses round-robin. On contention the port != last wins.
//    - last updates to the granted port on every accept.
//    - wait_cnt and MAX_WAIT are unused (counter not instantiated). LOCK0 behaves as above.
//  Undefined: fixed priority with starvation guard as in BEHAVIOUR.
// STRUCTURE
//  Shared package dram_pkg:
//    - funct3 localparams SB/SH/SW/LB/LH/LW/LBU/LHU.
//    - Arbiter state encoding ARB_IDLE/ARB_LOCK0.
//    - Port index constants P_CORE=0, P_DMA=1.
//  One sub-module: dram_arb_pick (combinational 2-way winner select: valids, last/force, lock -> grant vector).
//  Mux, FSM and return path live in the top.
// TESTING
//  1. Only m0 load to addr 0x10, op LW -> m0_ready=1 that cycle, mem_rd=1, mem_addr=0x10.
//     Next cycle m0_rvalid=1, m0_rdata=mem_rdata, m1_rvalid=0.
//  2. Fixed priority, m0 and m1 valid continuously, MAX_WAIT=8 ->
//     - m1 granted on cycle 9.
//     - wait_cnt back to 0; m0 wins cycle 10.
//  3. m0 SW with lock=1, then m0 idle 3 cycles while m1 valid ->
//     - m1_ready=0 throughout.
//     - m0 SW with lock=0 releases; m1 granted next cycle.
//  4. Back-to-back loads m0, m1, m0 (RR build, m0 then m1 idle gaps) ->
//     - rvalid pulses steered to m0, m1, m0 in consecutive cycles.
//     - Data matches each issued address.
//  5. RR build, both valid 4 cycles from reset -> grants m0, m1, m0, m1 (last=1 at reset).
//  6. rst asserted cycle after accepted m1 load while in LOCK0 ->
//     - m1_rvalid=0, state=IDLE.
//     - After release, m1 can be granted.

Source files
------------

// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared constants for the data-RAM port arbiter
package dram_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_LOCK0 = 1'b1;

  localparam logic P_CORE = 1'b0;
  localparam logic P_DMA  = 1'b1;

endpackage

// File: rtl/dram_arb_pick.sv
// rtl/dram_arb_pick.sv - combinational 2-way winner select
module dram_arb_pick (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       lock0,
  input  logic       prefer1,
  output logic [1:0] grant
);

  // prefer1 only breaks a tie; a lone requester always wins unless port 0 holds the lock
  always_comb begin
    grant = 2'b00;
    if (lock0)
      grant[0] = valid0;
    else if (valid0 && valid1)
      grant = prefer1 ? 2'b10 : 2'b01;
    else
      grant = {valid1, valid0};
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - two-port data-RAM arbiter; DRAM_ARB_RR_EN selects round-robin
module dram_port_arbiter
  import dram_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          m0_valid,
  input  logic          m0_wr,
  input  logic [2:0]    m0_op,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_ready,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_valid,
  input  logic          m1_wr,
  input  logic [2:0]    m1_op,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [2:0]    mem_op,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [0:0] state;
  logic       rpend;
  logic       rsel;
  logic       prefer1;
  logic [1:0] pick_grant;
  logic [1:0] grant;

  dram_arb_pick u_pick (
    .valid0  (m0_valid),
    .valid1  (m1_valid),
    .lock0   (state == ARB_LOCK0),
    .prefer1 (prefer1),
    .grant   (pick_grant)
  );

  // nothing is granted while reset is held, so every RAM-side output stays 0
  assign grant    = pick_grant & {2{~rst}};
  assign m0_ready = grant[0];
  assign m1_ready = grant[1];

`ifdef DRAM_ARB_RR_EN
  logic last;

  assign prefer1 = (last == P_CORE);

  always_ff @(posedge sclk) begin
    if (rst)
      last <= P_DMA;
    else if (|grant)
      last <= grant[1];
  end
`else
  logic [7:0] wait_cnt;

  assign prefer1 = (wait_cnt >= 8'(MAX_WAIT));

  always_ff @(posedge sclk) begin
    if (rst)
      wait_cnt <= 8'd0;
    else if (!m1_valid || grant[1])
      wait_cnt <= 8'd0;
    else if (wait_cnt != 8'hFF)
      wait_cnt <= wait_cnt + 8'd1;
  end
`endif

  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_op    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant[0]) begin
      mem_wr    = m0_wr;
      mem_rd    = !m0_wr;
      mem_op    = m0_op;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (grant[1]) begin
      mem_wr    = m1_wr;
      mem_rd    = !m1_wr;
      mem_op    = m1_op;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state <= ARB_IDLE;
      rpend <= 1'b0;
      rsel  <= P_CORE;
    end else begin
      rpend <= mem_rd;
      rsel  <= grant[1];
      if (grant[0])
        state <= m0_lock ? ARB_LOCK0 : ARB_IDLE;
    end
  end

  assign m0_rvalid = rpend && (rsel == P_CORE) && !rst;
  assign m1_rvalid = rpend && (rsel == P_DMA) && !rst;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;
  import dram_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 8;

  typedef struct packed {
    logic        v;
    logic        w;
    logic        lk;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  typedef struct {
    req_t        p0;
    req_t        p1;
    logic        e_r0;
    logic        e_r1;
    logic        e_wr;
    logic        e_rd;
    logic [31:0] e_addr;
  } vec_t;

  logic sclk = 1'b0;
  logic rst = 1'b1;
  logic m0_valid = 1'b0, m0_wr = 1'b0, m0_lock = 1'b0;
  logic [2:0] m0_op = '0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic m0_ready, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic m1_valid = 1'b0, m1_wr = 1'b0;
  logic [2:0] m1_op = '0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic m1_ready, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic mem_wr, mem_rd;
  logic [2:0] mem_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          md_lock = 1'b0;
  int          md_wait = 0;
  bit          md_last = 1'b1;
  bit          pend_v = 1'b0;
  bit          pend_p = 1'b0;
  logic [31:0] pend_a = '0;

  logic        obs_r0, obs_r1, obs_rv0, obs_rv1, obs_wr, obs_rd;
  logic [31:0] obs_addr, obs_rd0, obs_rd1;

  vec_t vecs[6];

  dram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .sclk(sclk), .rst(rst),
    .m0_valid(m0_valid), .m0_wr(m0_wr), .m0_op(m0_op), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_ready(m0_ready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wr(m1_wr), .m1_op(m1_op), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 sclk = ~sclk;

  function automatic logic [31:0] rd_hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // RAM stand-in: one-cycle read latency, data derived from the address
  always @(posedge sclk) if (mem_rd) mem_rdata <= rd_hash(mem_addr);

  function automatic req_t rq(input logic v, input logic w, input logic [2:0] op,
                              input logic [31:0] a, input logic lk = 1'b0);
    req_t q;
    q.v = v; q.w = w; q.lk = lk; q.op = op; q.a = a; q.d = a ^ 32'hC0DE_0000;
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input req_t p0, input req_t p1);
    int g;
    logic ewr, erd, erv0, erv1;
    logic [2:0] eop;
    logic [31:0] eaddr, ewd;
    rst = r;
    m0_valid = p0.v; m0_wr = p0.w; m0_lock = p0.lk; m0_op = p0.op; m0_addr = p0.a; m0_wdata = p0.d;
    m1_valid = p1.v; m1_wr = p1.w; m1_op = p1.op; m1_addr = p1.a; m1_wdata = p1.d;
    @(negedge sclk);
    g = -1;
    if (!r) begin
      if (md_lock) begin
        if (p0.v) g = 0;
      end else if (p0.v && p1.v) begin
`ifdef DRAM_ARB_RR_EN
        g = (md_last == 1'b0) ? 1 : 0;
`else
        g = (md_wait >= MAX_WAIT) ? 1 : 0;
`endif
      end else if (p0.v) g = 0;
      else if (p1.v) g = 1;
    end
    ewr = (g == 0) ? p0.w : (g == 1) ? p1.w : 1'b0;
    erd = (g >= 0) && !ewr;
    eop = (g == 0) ? p0.op : (g == 1) ? p1.op : 3'd0;
    eaddr = (g == 0) ? p0.a : (g == 1) ? p1.a : 32'd0;
    ewd = (g == 0) ? p0.d : (g == 1) ? p1.d : 32'd0;
    erv0 = !r && pend_v && !pend_p;
    erv1 = !r && pend_v && pend_p;
    obs_r0 = m0_ready; obs_r1 = m1_ready; obs_wr = mem_wr; obs_rd = mem_rd;
    obs_addr = mem_addr; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata; obs_rd1 = m1_rdata;
    chk("m0_ready", m0_ready, (g == 0));
    chk("m1_ready", m1_ready, (g == 1));
    chk("mem_wr", mem_wr, ewr);
    chk("mem_rd", mem_rd, erd);
    chk("mem_op", mem_op, eop);
    chk("mem_addr", mem_addr, eaddr);
    chk("mem_wdata", mem_wdata, ewd);
    chk("m0_rvalid", m0_rvalid, erv0);
    chk("m1_rvalid", m1_rvalid, erv1);
    chk("m0_rdata", m0_rdata, erv0 ? rd_hash(pend_a) : 32'd0);
    chk("m1_rdata", m1_rdata, erv1 ? rd_hash(pend_a) : 32'd0);
    if (r) begin
      md_lock = 1'b0; md_wait = 0; md_last = 1'b1; pend_v = 1'b0;
    end else begin
      pend_v = erd; pend_p = (g == 1); pend_a = eaddr;
      if (g >= 0) md_last = (g == 1);
      if (g == 0) md_lock = p0.lk;
      if (!p1.v || g == 1) md_wait = 0;
      else if (md_wait < 255) md_wait++;
    end
    @(posedge sclk);
    #1;
  endtask

  initial begin
    req_t idle;
    idle = rq(1'b0, 1'b0, 3'd0, 32'd0);
    vecs[0] = '{rq(1, 0, LW, 32'h10), rq(1, 0, LW, 32'h20), 1'b1, 1'b0, 1'b0, 1'b1, 32'h10};
    vecs[1] = '{idle, rq(1, 1, SW, 32'h24), 1'b0, 1'b1, 1'b1, 1'b0, 32'h24};
    vecs[2] = '{idle, idle, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{rq(1, 1, SB, 32'h3), idle, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3};
    vecs[4] = '{idle, rq(1, 0, LHU, 32'h44), 1'b0, 1'b1, 1'b0, 1'b1, 32'h44};
    vecs[5] = '{rq(1, 0, LB, 32'h100), idle, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100};

    cyc(1'b1, rq(1, 0, LW, 32'h8), rq(1, 0, LW, 32'hC));
    cyc(1'b1, idle, idle);
    chk("reset_m0_ready", obs_r0, 1'b0);
    chk("reset_mem_addr", obs_addr, 32'd0);

    foreach (vecs[i]) begin
      cyc(1'b0, vecs[i].p0, vecs[i].p1);
      chk($sformatf("vec%0d_m0_ready", i), obs_r0, vecs[i].e_r0);
      chk($sformatf("vec%0d_m1_ready", i), obs_r1, vecs[i].e_r1);
      chk($sformatf("vec%0d_mem_wr", i), obs_wr, vecs[i].e_wr);
      chk($sformatf("vec%0d_mem_rd", i), obs_rd, vecs[i].e_rd);
      chk($sformatf("vec%0d_mem_addr", i), obs_addr, vecs[i].e_addr);
    end
    cyc(1'b0, idle, idle);

    // single port-0 load and its return
    cyc(1'b0, rq(1, 0, LW, 32'h10), idle);
    chk("t1_m0_ready", obs_r0, 1'b1);
    chk("t1_mem_rd", obs_rd, 1'b1);
    chk("t1_mem_addr", obs_addr, 32'h10);
    cyc(1'b0, idle, idle);
    chk("t1_m0_rvalid", obs_rv0, 1'b1);
    chk("t1_m0_rdata", obs_rd0, rd_hash(32'h10));
    chk("t1_m1_rvalid", obs_rv1, 1'b0);

    // lock held across idle port-0 cycles
    cyc(1'b0, rq(1, 1, SW, 32'h80, 1'b1), idle);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, idle, rq(1, 0, LW, 32'h90));
      chk("t3_m1_blocked", obs_r1, 1'b0);
    end
    cyc(1'b0, rq(1, 1, SW, 32'h84, 1'b0), rq(1, 0, LW, 32'h90));
    chk("t3_release_m0", obs_r0, 1'b1);
    chk("t3_release_m1", obs_r1, 1'b0);
    cyc(1'b0, idle, rq(1, 0, LW, 32'h90));
    chk("t3_m1_after", obs_r1, 1'b1);

    // pipelined loads, returns steered per issuer
    cyc(1'b0, rq(1, 0, LW, 32'h200), idle);
    cyc(1'b0, idle, rq(1, 0, LW, 32'h300));
    chk("t4_rv0_a", obs_rv0, 1'b1);
    chk("t4_rd0_a", obs_rd0, rd_hash(32'h200));
    cyc(1'b0, rq(1, 0, LW, 32'h400), idle);
    chk("t4_rv1", obs_rv1, 1'b1);
    chk("t4_rd1", obs_rd1, rd_hash(32'h300));
    cyc(1'b0, idle, idle);
    chk("t4_rv0_b", obs_rv0, 1'b1);
    chk("t4_rd0_b", obs_rd0, rd_hash(32'h400));

`ifdef DRAM_ARB_RR_EN
    cyc(1'b1, idle, idle);
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b0, rq(1, 0, LW, 32'(c)), rq(1, 0, LW, 32'(c + 16)));
      chk($sformatf("t5_m0_ready_c%0d", c), obs_r0, (c % 2) == 1);
      chk($sformatf("t5_m1_ready_c%0d", c), obs_r1, (c % 2) == 0);
    end
`else
    for (int c = 1; c <= 10; c++) begin
      cyc(1'b0, rq(1, 0, LW, 32'(c)), rq(1, 0, LW, 32'(c + 16)));
      chk($sformatf("t2_m1_ready_c%0d", c), obs_r1, c == 9);
      chk($sformatf("t2_m0_ready_c%0d", c), obs_r0, c != 9);
    end
`endif
    cyc(1'b0, idle, idle);

    // reset while locked, and reset dropping a pending return
    cyc(1'b0, rq(1, 1, SW, 32'hA0, 1'b1), idle);
    cyc(1'b0, idle, rq(1, 0, LW, 32'hB0));
    chk("t6_m1_locked", obs_r1, 1'b0);
    cyc(1'b1, idle, rq(1, 0, LW, 32'hB0));
    chk("t6_rst_rv1", obs_rv1, 1'b0);
    cyc(1'b0, idle, rq(1, 0, LW, 32'hB4));
    chk("t6_m1_granted", obs_r1, 1'b1);
    cyc(1'b1, idle, idle);
    chk("t6_drop_rv1_a", obs_rv1, 1'b0);
    cyc(1'b0, idle, idle);
    chk("t6_drop_rv1_b", obs_rv1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      req_t a, b;
      a = rq($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
             $urandom, $urandom_range(0, 7) == 0);
      b = rq($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
             $urandom);
      cyc($urandom_range(0, 99) == 0, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
